keyboard_decoder: RTL
=====================

// Module: keyboard_decoder
// PURPOSE
//  PS/2 keyboard front end. Receives set-2 scan codes and turns them into one game operation at a time.
//  Holds that operation for the game-logic stage directly downstream using a ready/read_fin handshake.
//  Only the first-layer game keys, arrow keys and their break sequences matter; every other code is discarded.
// PARAMETERS
//  SYNC_STAGES     2      flip-flop stages on ps2_clock/ps2_data (min 2)
//  TIMEOUT_CYCLES  50000  idle clock cycles mid-frame before frame is abandoned (1 ms @ 50 MHz)
//  LOG2_TIMEOUT    16     width of timeout counter (must hold TIMEOUT_CYCLES)
// PORTS
//  clock              in   1  system clock
//  reset              in   1  asynchronous reset, ACTIVE-LOW (0 = reset)
//  ps2_clock          in   1  raw PS/2 clock line, asynchronous
//  ps2_data           in   1  raw PS/2 data line, asynchronous
//  keyboard_read_fin  in   1  consumer acknowledge: 1 = held operation taken
//  keyboard_ready     out  1  1 = keyboard_data holds an unread operation
//  keyboard_data      out  3  W=000 A=001 S=010 D=011 SPACE=100 Z=101; NONE=110 when not ready
//  frame_error        out  1  one-cycle pulse: parity/start/stop error or timeout
// BEHAVIOUR
//  Reset (reset=0, async)
//   - keyboard_ready=0, keyboard_data=110, frame_error=0.
//   - Both FSMs return to IDLE/BASE; synchronisers are filled with 1.
//  Bit level
//   - A bit is sampled on each synchronised falling edge of ps2_clock.
//   - Frame: start(0), 8 data bits LSB first, odd parity, stop(1).
//   - A byte is valid when start=0, stop=1 and odd parity over data+parity holds.
//   - Otherwise the byte is dropped and frame_error pulses.
//  Bit FSM
//   - IDLE -> RX on the first falling edge (start bit).
//   - RX counts bits 1..10; after the 11th it returns to IDLE and emits byte_valid for one cycle.
//   - Timeout counter clears on every falling edge. When it reaches TIMEOUT_CYCLES in RX:
//     return to IDLE, pulse frame_error, discard the partial byte.
//  Code FSM (advances only on byte_valid)
//   - BASE:     F0->BRK; E0->EXT; a game code -> emit op; anything else is ignored.
//   - BRK:      any byte -> BASE (release, no op).
//   - EXT:      F0->EXT_BRK; 75->W, 6B->A, 72->S, 74->D (emit), then BASE; other bytes -> BASE.
//   - EXT_BRK:  any byte -> BASE.
//   - Game codes: 1D=W 1C=A 1B=S 23=D 29=SPACE 1A=Z.
//   - Unknown bytes never raise frame_error.
//  Handshake (single-entry holding register)
//   - Emit: keyboard_data<=op and keyboard_ready<=1 on the next edge. Latency is 1 cycle after byte_valid.
//   - Consumer: while keyboard_ready=1 and keyboard_read_fin=1, clear keyboard_ready and set keyboard_data=110 next edge.
//   - read_fin while keyboard_ready=0 is ignored. The consumer may hold read_fin high 1 cycle past the drop.
//   - Emit while already ready: newer op overwrites, ready stays 1 (latest wins).
//   - Emit and read_fin in the same cycle: the new op wins and ready stays 1. The old op counts as consumed.
//  Mid-operation reset: abandons the frame and any held op; no output glitch after release.
// CONFIGURATION
//  KBD_REPEAT_FILTER_EN defined
//   - Tracks the currently held game key (BASE and EXT paths separately).
//   - A make code equal to the held key with no intervening break is dropped (typematic repeat suppressed).
//   - The matching break clears the held key. A different make replaces it.
//  KBD_REPEAT_FILTER_EN undefined
//   - Every make code, including typematic repeats, emits an op.
// STRUCTURE
//  Shared package game_pkg
//   - Operation enum (W..NONE, 3 bits).
//   - Scan-code localparams (SC_W, SC_A, ..., SC_BREAK=F0, SC_EXT=E0, SC_UP/LEFT/DOWN/RIGHT).
//  Sub-module ps2_rx_frame
//   - Contains the synchroniser, edge detection, bit FSM, timeout and parity check.
//   - Outputs byte_valid, byte_data[7:0] and frame_error to the code FSM and handshake in keyboard_decoder.
// TESTING
//  1. Frame 1D -> keyboard_ready=1, keyboard_data=000; read_fin=1 for 1 cycle -> ready=0, data=110 next edge.
//  2. Bytes F0 1D (release W) -> no ready; then E0 6B -> data=001 (A), ready=1.
//  3. Frame 1C with even parity -> frame_error 1-cycle pulse, no ready. Next valid 29 -> data=100.
//  4. Five data bits of 23, then 50000 idle cycles -> frame_error pulse; full 1A afterwards -> data=101.
//  5. 1D then 1B with no read_fin -> data=010, ready=1. read_fin on the same cycle as a new 23 -> data=011, ready=1.
//  6. 1D 1D 1D (no F0), consumer acks each:
//     - KBD_REPEAT_FILTER_EN defined: exactly 1 op.
//     - KBD_REPEAT_FILTER_EN undefined: 3 ops.
//     - Then F0 1D 1D -> 1 more op in both builds.
//  Also: reset low mid-frame and mid-ready -> outputs 0/110 immediately (async), clean decode after release.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game operation encoding, PS/2 set-2 scan codes and scan-code decode helpers.
package game_pkg;

    typedef enum logic [2:0] {
        OP_W     = 3'b000,
        OP_A     = 3'b001,
        OP_S     = 3'b010,
        OP_D     = 3'b011,
        OP_SPACE = 3'b100,
        OP_Z     = 3'b101,
        OP_NONE  = 3'b110
    } op_e;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_Z     = 8'h1A;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    function automatic op_e decode_base(input logic [7:0] code);
        case (code)
            SC_W:     return OP_W;
            SC_A:     return OP_A;
            SC_S:     return OP_S;
            SC_D:     return OP_D;
            SC_SPACE: return OP_SPACE;
            SC_Z:     return OP_Z;
            default:  return OP_NONE;
        endcase
    endfunction

    function automatic op_e decode_ext(input logic [7:0] code);
        case (code)
            SC_UP:    return OP_W;
            SC_LEFT:  return OP_A;
            SC_DOWN:  return OP_S;
            SC_RIGHT: return OP_D;
            default:  return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: line synchroniser, falling-edge detect, bit FSM, idle timeout and frame check.
module ps2_rx_frame #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOG2_TIMEOUT   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error
);

    typedef enum logic {RX_IDLE, RX_BITS} rx_state_e;

    rx_state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0]  clk_sync, data_sync;
    logic                    clk_prev;
    logic                    fall;
    logic [3:0]              bit_cnt;
    logic [9:0]              shreg;
    logic [10:0]             frame_next;
    logic [LOG2_TIMEOUT-1:0] timer;
    logic                    frame_done, frame_ok, timed_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clock};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];

    // Bit 0 = start, 1..8 = data LSB first, 9 = parity, 10 = stop (the bit arriving now).
    assign frame_next = {data_sync[SYNC_STAGES-1], shreg};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= RX_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE: if (fall) state_d = RX_BITS;
            RX_BITS: if (frame_done || timed_out) state_d = RX_IDLE;
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        frame_done = (state_q == RX_BITS) && fall && (bit_cnt == 4'd10);
        timed_out  = (state_q == RX_BITS) && !fall && (timer == LOG2_TIMEOUT'(TIMEOUT_CYCLES));
        frame_ok   = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            timer       <= '0;
            byte_valid  <= 1'b0;
            byte_data   <= '0;
            frame_error <= 1'b0;
        end else begin
            byte_valid  <= frame_done & frame_ok;
            frame_error <= (frame_done & ~frame_ok) | timed_out;
            if (frame_done && frame_ok) byte_data <= frame_next[8:1];
            if (fall) begin
                shreg   <= {data_sync[SYNC_STAGES-1], shreg[9:1]};
                bit_cnt <= (state_q == RX_IDLE) ? 4'd1 : bit_cnt + 4'd1;
            end
            if (state_q == RX_IDLE || fall) timer <= '0;
            else                            timer <= timer + 1'b1;
        end
    end

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 keyboard front end: scan-code FSM plus single-entry ready/read_fin holding register.
// Optional typematic repeat suppression when KBD_REPEAT_FILTER_EN is defined.
module keyboard_decoder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOG2_TIMEOUT   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    input  logic       keyboard_read_fin,
    output logic       keyboard_ready,
    output logic [2:0] keyboard_data,
    output logic       frame_error
);

    import game_pkg::*;

    typedef enum logic [1:0] {CODE_BASE, CODE_BRK, CODE_EXT, CODE_EXT_BRK} code_state_e;

    code_state_e code_q, code_d;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        emit;
    op_e         emit_op;
    op_e         data_q;

    ps2_rx_frame #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .LOG2_TIMEOUT  (LOG2_TIMEOUT)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clock  (ps2_clock),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_error(frame_error)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) code_q <= CODE_BASE;
        else        code_q <= code_d;
    end

    always_comb begin
        code_d = code_q;
        if (byte_valid) begin
            case (code_q)
                CODE_BASE: begin
                    if (byte_data == SC_BREAK)    code_d = CODE_BRK;
                    else if (byte_data == SC_EXT) code_d = CODE_EXT;
                end
                CODE_EXT: code_d = (byte_data == SC_BREAK) ? CODE_EXT_BRK : CODE_BASE;
                default:  code_d = CODE_BASE;
            endcase
        end
    end

`ifdef KBD_REPEAT_FILTER_EN
    op_e held_base_q, held_ext_q;

    // A release only clears the held key when it names that same key.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            held_base_q <= OP_NONE;
            held_ext_q  <= OP_NONE;
        end else if (byte_valid) begin
            case (code_q)
                CODE_BASE:
                    if (decode_base(byte_data) != OP_NONE) held_base_q <= decode_base(byte_data);
                CODE_BRK:
                    if (decode_base(byte_data) == held_base_q) held_base_q <= OP_NONE;
                CODE_EXT:
                    if (decode_ext(byte_data) != OP_NONE) held_ext_q <= decode_ext(byte_data);
                CODE_EXT_BRK:
                    if (decode_ext(byte_data) == held_ext_q) held_ext_q <= OP_NONE;
                default: ;
            endcase
        end
    end
`endif

    always_comb begin
        emit    = 1'b0;
        emit_op = OP_NONE;
        if (byte_valid) begin
            case (code_q)
                CODE_BASE: begin
                    emit_op = decode_base(byte_data);
                    emit    = (emit_op != OP_NONE);
`ifdef KBD_REPEAT_FILTER_EN
                    if (emit_op == held_base_q) emit = 1'b0;
`endif
                end
                CODE_EXT: begin
                    emit_op = decode_ext(byte_data);
                    emit    = (emit_op != OP_NONE);
`ifdef KBD_REPEAT_FILTER_EN
                    if (emit_op == held_ext_q) emit = 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    // A new op takes priority over a same-cycle acknowledge; the older op is treated as consumed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            keyboard_ready <= 1'b0;
            data_q         <= OP_NONE;
        end else if (emit) begin
            keyboard_ready <= 1'b1;
            data_q         <= emit_op;
        end else if (keyboard_ready && keyboard_read_fin) begin
            keyboard_ready <= 1'b0;
            data_q         <= OP_NONE;
        end
    end

    assign keyboard_data = data_q;

endmodule
